mem_bus_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the shared data-memory / memory-mapped-IO bus. It sits between the CPU's memory-or-IO access path, the UART program/data loader and the two downstream resources: the data-memory block RAM and the IO peripheral bus (LEDs, switches). It decodes each access as memory or IO and grants one transaction at a time. It waits out the block-RAM read latency and returns a one-cycle acknowledge with read data. While a CPU access is pending, it stalls the CPU.

---
 rtl/mem_bus_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter/sequencer that routes CPU and loader accesses to block RAM or the IO bus.
// Only one transaction is in flight at a time: IDLE -> ISSUE -> (WAIT) -> ACK -> IDLE.
module mem_bus_arbiter #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FC00,
  parameter int unsigned RD_LAT  = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        c_req,
  input  logic        c_we,
  input  logic [31:0] c_addr,
  input  logic [31:0] c_wdata,
  output logic [31:0] c_rdata,
  output logic        c_ack,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic [31:0] l_rdata,
  output logic        l_ack,
  output logic        cpu_stall,
  output logic        m_en,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        io_en,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wdata,
  input  logic [15:0] io_rdata
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and latch the winner
  // ISSUE | one-cycle strobe to RAM or IO; IO read data captured here
  // WAIT  | RD_LAT cycles of block-RAM read latency
  // ACK   | one-cycle ack pulse to the winner; round-robin pointer updated
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [1:0] WAIT_LOAD = 2'(RD_LAT - 1);

  state_t      state;
  logic        owner;        // 0 = CPU, 1 = loader
  logic        prio_loader;  // loader wins the next tie
  logic        cmd_we;
  logic        cmd_io;
  logic [1:0]  wait_cnt;

  logic        grant_l;
  logic        sel_we;
  logic        sel_io;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [31:0] issue_data;

  always_comb begin
    grant_l    = l_req & (~c_req | prio_loader);
    sel_we     = grant_l ? l_we    : c_we;
    sel_addr   = grant_l ? l_addr  : c_addr;
    sel_wdata  = grant_l ? l_wdata : c_wdata;
    sel_io     = (sel_addr[31:10] == IO_BASE[31:10]);
    issue_data = (cmd_io && !cmd_we) ? {16'b0, io_rdata} : 32'b0;
  end

  assign cpu_stall = c_req & ~c_ack;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      prio_loader <= 1'b0;
      cmd_we      <= 1'b0;
      cmd_io      <= 1'b0;
      wait_cnt    <= 2'd0;
      c_ack       <= 1'b0;
      l_ack       <= 1'b0;
      c_rdata     <= 32'b0;
      l_rdata     <= 32'b0;
      m_en        <= 1'b0;
      m_we        <= 1'b0;
      m_addr      <= 32'b0;
      m_wdata     <= 32'b0;
      io_en       <= 1'b0;
      io_we       <= 1'b0;
      io_addr     <= 32'b0;
      io_wdata    <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (c_req | l_req) begin
            owner    <= grant_l;
            cmd_we   <= sel_we;
            cmd_io   <= sel_io;
            // strobe registers double as the latched command for ISSUE
            m_en     <= ~sel_io;
            m_we     <= ~sel_io & sel_we;
            m_addr   <= sel_io ? 32'b0 : sel_addr;
            m_wdata  <= sel_io ? 32'b0 : sel_wdata;
            io_en    <= sel_io;
            io_we    <= sel_io & sel_we;
            io_addr  <= sel_io ? sel_addr  : 32'b0;
            io_wdata <= sel_io ? sel_wdata : 32'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          m_en     <= 1'b0;
          m_we     <= 1'b0;
          m_addr   <= 32'b0;
          m_wdata  <= 32'b0;
          io_en    <= 1'b0;
          io_we    <= 1'b0;
          io_addr  <= 32'b0;
          io_wdata <= 32'b0;
          wait_cnt <= WAIT_LOAD;
          if (cmd_we || cmd_io) begin
            c_ack   <= ~owner;
            l_ack   <= owner;
            c_rdata <= owner ? 32'b0 : issue_data;
            l_rdata <= owner ? issue_data : 32'b0;
            state   <= ACK;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            c_ack   <= ~owner;
            l_ack   <= owner;
            c_rdata <= owner ? 32'b0 : m_rdata;
            l_rdata <= owner ? m_rdata : 32'b0;
            state   <= ACK;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ACK: begin
          c_ack       <= 1'b0;
          l_ack       <= 1'b0;
          c_rdata     <= 32'b0;
          l_rdata     <= 32'b0;
          prio_loader <= ~owner;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: two instances (RD_LAT 1 and 3), each with its own stimulus,
// memory/IO stubs and a cycle-level reference model feeding a scoreboard.
module tb_mem_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  function automatic bit in_io(input logic [31:0] a);
    return (a & 32'hFFFF_FC00) == 32'hFFFF_FC00;
  endfunction

  // power-up contents of the data RAM, shared by the stub and the reference model
  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 32'hFFFF_FC00 + 32'(4 * $urandom_range(0, 15));
    return 32'(4 * $urandom_range(0, 15));
  endfunction

  task automatic chk(input int ln, input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL lane%0d %s @cyc %0d: got %h, expected %h", ln, nm, cyc, act, want);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT = (g == 0) ? 1 : 3;

    logic        reset = 1'b1;
    logic        c_req, c_we, l_req, l_we;
    logic [31:0] c_addr, c_wdata, l_addr, l_wdata;
    logic [31:0] c_rdata, l_rdata;
    logic        c_ack, l_ack, cpu_stall;
    logic        m_en, m_we, io_en, io_we;
    logic [31:0] m_addr, m_wdata, io_addr, io_wdata;
    logic [31:0] m_rdata = 32'b0;
    logic [15:0] io_rdata = 16'b0;
    bit          fin = 1'b0;

    txn_t cq[$];
    txn_t lq[$];
    int   ack_log[$];

    mem_bus_arbiter #(.IO_BASE(32'hFFFF_FC00), .RD_LAT(LAT)) dut (
      .clock(clock), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_rdata(c_rdata), .c_ack(c_ack),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_rdata(l_rdata), .l_ack(l_ack),
      .cpu_stall(cpu_stall),
      .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
      .io_en(io_en), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    // downstream stubs: RAM data valid only in the cycle RD_LAT after the strobe, junk otherwise
    logic [31:0] ram[logic [31:0]];
    logic [15:0] ioreg[logic [31:0]];
    int          rd_left = 0;
    logic [31:0] rd_val = 32'b0;

    initial forever begin
      @(negedge clock);
      if (m_en && m_we) ram[m_addr] = m_wdata;
      if (m_en && !m_we) begin
        rd_left = LAT + 1;
        rd_val  = ram.exists(m_addr) ? ram[m_addr] : mem_init(m_addr);
      end else if (rd_left > 0) begin
        rd_left--;
      end
      m_rdata = (rd_left == 1) ? rd_val : $urandom();
      if (io_en && io_we) ioreg[io_addr] = io_wdata[15:0];
      if (io_en && !io_we) io_rdata = ioreg.exists(io_addr) ? ioreg[io_addr] : 16'hFFFF;
      else io_rdata = 16'($urandom());
    end

    // reference model: bus is free or owned by one transaction granted at cycle gcyc
    bit          busy = 1'b0;
    bit          armed = 1'b0;
    bit          last_l = 1'b1;
    bit          win = 1'b0;
    int          gcyc = 0;
    int          ack_cyc = 0;
    txn_t        cur;
    logic [31:0] ref_mem[logic [31:0]];
    logic [15:0] ref_io[logic [31:0]];
    logic [1:0]  e_ack;
    logic [3:0]  e_str;
    logic [31:0] e_crd, e_lrd, e_ma, e_mw, e_ia, e_iw, rd;

    initial forever begin
      @(negedge clock);
      e_ack = 2'b00; e_str = 4'b0000;
      e_crd = 32'b0; e_lrd = 32'b0; e_ma = 32'b0; e_mw = 32'b0; e_ia = 32'b0; e_iw = 32'b0;
      if (busy && cyc == gcyc + 1) begin
        if (in_io(cur.addr)) begin
          e_str = {2'b00, 1'b1, cur.we}; e_ia = cur.addr; e_iw = cur.wdata;
        end else begin
          e_str = {1'b1, cur.we, 2'b00}; e_ma = cur.addr; e_mw = cur.wdata;
        end
      end
      if (busy && cyc == ack_cyc) begin
        e_ack = win ? 2'b01 : 2'b10;
        rd = 32'b0;
        if (cur.we) begin
          if (in_io(cur.addr)) ref_io[cur.addr] = cur.wdata[15:0];
          else ref_mem[cur.addr] = cur.wdata;
        end else if (in_io(cur.addr)) begin
          rd = {16'h0, ref_io.exists(cur.addr) ? ref_io[cur.addr] : 16'hFFFF};
        end else begin
          rd = ref_mem.exists(cur.addr) ? ref_mem[cur.addr] : mem_init(cur.addr);
        end
        if (win) e_lrd = rd; else e_crd = rd;
      end
      if (armed) begin
        chk(g, "acks {c,l}", 32'({c_ack, l_ack}), 32'(e_ack));
        chk(g, "c_rdata", c_rdata, e_crd);
        chk(g, "l_rdata", l_rdata, e_lrd);
        chk(g, "strobes {m_en,m_we,io_en,io_we}", 32'({m_en, m_we, io_en, io_we}), 32'(e_str));
        chk(g, "m_addr", m_addr, e_ma);
        chk(g, "m_wdata", m_wdata, e_mw);
        chk(g, "io_addr", io_addr, e_ia);
        chk(g, "io_wdata", io_wdata, e_iw);
        chk(g, "cpu_stall", 32'(cpu_stall), 32'(c_req & ~e_ack[1]));
      end
      if (c_ack) ack_log.push_back(0);
      if (l_ack) ack_log.push_back(1);
      if (reset) begin
        busy = 1'b0; last_l = 1'b1; armed = 1'b1;
      end else if (busy && cyc == ack_cyc) begin
        busy = 1'b0; last_l = win;
        if (win) void'(lq.pop_front()); else void'(cq.pop_front());
      end else if (!busy && (c_req || l_req)) begin
        win = (c_req && l_req) ? ~last_l : l_req;
        if (win ? (lq.size() == 0) : (cq.size() == 0)) begin
          chk(g, "request without issued transaction", 32'd0, 32'd1);
        end else begin
          cur = win ? lq[0] : cq[0];
          busy = 1'b1;
          gcyc = cyc;
          ack_cyc = cyc + 2 + ((!cur.we && !in_io(cur.addr)) ? LAT : 0);
        end
      end
    end

    task automatic drive(input bit who, input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d);
      if (who) begin l_req = rq; l_we = we; l_addr = a; l_wdata = d; end
      else begin c_req = rq; c_we = we; c_addr = a; c_wdata = d; end
    endtask

    task automatic do_txn(input bit who, input bit we, input logic [31:0] a, input logic [31:0] d,
                          input bit drop, input int exp_lat);
      int   t0;
      bit   got;
      txn_t t;
      got = 1'b0;
      @(posedge clock); #1;
      t.we = we; t.addr = a; t.wdata = d;
      if (who) lq.push_back(t); else cq.push_back(t);
      drive(who, 1'b1, we, a, d);
      t0 = cyc;
      if (drop) begin
        @(posedge clock); #1;
        drive(who, 1'b0, we, a, d);
      end
      for (int n = 0; n < 60 && !got; n++) begin
        @(negedge clock);
        got = who ? l_ack : c_ack;
      end
      chk(g, "ack seen before timeout", 32'(got), 32'd1);
      if (got && exp_lat >= 0) chk(g, "ack latency", 32'(cyc - t0), 32'(exp_lat));
      @(posedge clock); #1;
      drive(who, 1'b0, 1'b0, 32'b0, 32'b0);
    endtask

    initial begin
      drive(1'b0, 1'b0, 1'b0, 32'b0, 32'b0);
      drive(1'b1, 1'b0, 1'b0, 32'b0, 32'b0);
      for (int i = 0; i < 2; i++) begin
        @(posedge clock); #1;
        drive(1'b0, 1'($urandom()), 1'($urandom()), $urandom(), $urandom());
        drive(1'b1, 1'($urandom()), 1'($urandom()), $urandom(), $urandom());
      end
      @(posedge clock); #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'b0, 32'b0);
      drive(1'b1, 1'b0, 1'b0, 32'b0, 32'b0);

      do_txn(1'b0, 1'b1, 32'h4, 32'h0F0F_0F0F, 1'b0, 2);
      do_txn(1'b1, 1'b1, 32'h4, 32'hFFFF_0001, 1'b0, 2);
      do_txn(1'b0, 1'b0, 32'h4, 32'h0, 1'b0, 2 + LAT);
      do_txn(1'b0, 1'b1, 32'hFFFF_FC60, 32'h0000_00A5, 1'b0, 2);
      do_txn(1'b0, 1'b0, 32'hFFFF_FC70, 32'h0, 1'b0, 2);
      do_txn(1'b1, 1'b0, 32'hFFFF_FC60, 32'h0, 1'b0, 2);
      do_txn(1'b0, 1'b0, 32'h8, 32'h0, 1'b1, 2 + LAT);

      // read aborted by reset while the RAM latency is being waited out
      @(posedge clock); #1;
      cq.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0});
      drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      @(posedge clock); #1;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 32'b0, 32'b0);
      cq.delete();
      repeat (6) @(posedge clock);

      // both requesters held from reset
      #1 reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      ack_log.delete();
      fork
        for (int i = 0; i < 2; i++) do_txn(1'b0, 1'($urandom()), rand_addr(), $urandom(), 1'b0, -1);
        for (int i = 0; i < 2; i++) do_txn(1'b1, 1'($urandom()), rand_addr(), $urandom(), 1'b0, -1);
      join
      chk(g, "contention ack count", 32'(ack_log.size()), 32'd4);
      for (int i = 0; i < 4 && i < ack_log.size(); i++)
        chk(g, "contention grant order", 32'(ack_log[i]), 32'(i % 2));

      fork
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(posedge clock);
          do_txn(1'b0, 1'($urandom()), rand_addr(), $urandom(), 1'b0, -1);
        end
        repeat (40) begin
          repeat ($urandom_range(0, 3)) @(posedge clock);
          do_txn(1'b1, 1'($urandom()), rand_addr(), $urandom(), 1'b0, -1);
        end
      join
      repeat (4) @(posedge clock);
      fin = 1'b1;
    end
  end

  initial begin
    fork
      wait (lane[0].fin && lane[1].fin);
      repeat (30000) @(posedge clock);
    join_any
    chk(0, "both lanes completed", 32'({lane[0].fin, lane[1].fin}), 32'd3);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
